// File: rtl/lcd_video_timing_pkg.sv
// lcd_pkg: shared types and defaults for the LCD video timing block.
//   - lcd_state_e : pixel sequencer state (RESYNC / SYNCED)
//   - DEF_*       : default 800x480 panel timing
//   - rgb888_t    : RGB888 pixel with pack/unpack helpers
package lcd_pkg;

    typedef enum logic [0:0] {
        RESYNC = 1'b0,
        SYNCED = 1'b1
    } lcd_state_e;

    localparam int DEF_CLKS_PER_PIXEL = 3;
    localparam int DEF_H_ACTIVE       = 800;
    localparam int DEF_H_FP           = 40;
    localparam int DEF_H_SYNC         = 48;
    localparam int DEF_H_BP           = 88;
    localparam int DEF_V_ACTIVE       = 480;
    localparam int DEF_V_FP           = 13;
    localparam int DEF_V_SYNC         = 3;
    localparam int DEF_V_BP           = 32;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Stream word layout is {R, G, B}, most significant byte first.
    function automatic rgb888_t rgb888_unpack(input logic [23:0] word);
        rgb888_t px;
        px.r = word[23:16];
        px.g = word[15:8];
        px.b = word[7:0];
        return px;
    endfunction

    function automatic logic [23:0] rgb888_pack(input rgb888_t px);
        return {px.r, px.g, px.b};
    endfunction

endpackage

// File: rtl/lcd_video_timing_if.sv
// lcd_video_timing_if: framebuffer FIFO pixel stream (valid/ready).
//   pix_data_i  : {R, G, B} pixel word
//   pix_sof_i   : word is the first pixel of a frame
//   pix_valid_i : word valid
//   pix_rdy_o   : word consumed this cycle (driven by the timing block)
// Signal names are from the timing block's point of view.
interface lcd_video_timing_if;
    logic [23:0] pix_data_i;
    logic        pix_sof_i;
    logic        pix_valid_i;
    logic        pix_rdy_o;

    modport master (output pix_data_i, output pix_sof_i, output pix_valid_i,
                    input  pix_rdy_o);
    modport slave  (input  pix_data_i, input  pix_sof_i, input  pix_valid_i,
                    output pix_rdy_o);
endinterface

// File: rtl/lcd_video_timing_cnt.sv
// lcd_timing_cnt: phase / horizontal / vertical counters and line decode.
//   clk, rst_n    : pixel clock, async active-low reset
//   hsync, vsync  : sync windows for the current counter position
//   active        : current position is inside the visible area
//   fetch_slot    : first clock of an active pixel
//   frame_origin  : hcnt = vcnt = phase = 0
// All decodes are combinational from the counter registers; the top
// registers them so every video output moves together.
module lcd_timing_cnt #(
    parameter int CLKS_PER_PIXEL = 3,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 32
) (
    input  logic clk,
    input  logic rst_n,
    output logic hsync,
    output logic vsync,
    output logic active,
    output logic fetch_slot,
    output logic frame_origin
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW = $clog2(CLKS_PER_PIXEL);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_PIXEL - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

    // Window bounds kept 32 bits wide so an end bound equal to the total
    // (zero back porch) still compares correctly.
    localparam logic [31:0] H_ACT_C = 32'(H_ACTIVE);
    localparam logic [31:0] HS_BEG  = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END  = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_C = 32'(V_ACTIVE);
    localparam logic [31:0] VS_BEG  = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END  = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0] phase_r;
    logic [HW-1:0] hcnt_r;
    logic [VW-1:0] vcnt_r;
    logic [31:0]   hcnt_s;
    logic [31:0]   vcnt_s;

    // Counter chain: phase wraps -> hcnt steps, hcnt wraps -> vcnt steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= '0;
            hcnt_r  <= '0;
            vcnt_r  <= '0;
        end else if (phase_r == PH_LAST) begin
            phase_r <= '0;
            if (hcnt_r == H_LAST) begin
                hcnt_r <= '0;
                if (vcnt_r == V_LAST) begin
                    vcnt_r <= '0;
                end else begin
                    vcnt_r <= vcnt_r + VW'(1);
                end
            end else begin
                hcnt_r <= hcnt_r + HW'(1);
            end
        end else begin
            phase_r <= phase_r + PW'(1);
        end
    end

    // Position decode against the line/frame windows.
    always_comb begin
        hcnt_s       = 32'(hcnt_r);
        vcnt_s       = 32'(vcnt_r);
        hsync        = (hcnt_s >= HS_BEG) && (hcnt_s < HS_END);
        vsync        = (vcnt_s >= VS_BEG) && (vcnt_s < VS_END);
        active       = (hcnt_s < H_ACT_C) && (vcnt_s < V_ACT_C);
        fetch_slot   = active && (phase_r == PW'(0));
        frame_origin = (phase_r == PW'(0)) && (hcnt_r == HW'(0)) && (vcnt_r == VW'(0));
    end

endmodule

// File: rtl/lcd_video_timing.sv
// lcd_video_timing: video timing generator and pixel sequencer.
//   pixel_clk_i, pixel_rst_n_i : clock, async active-low reset
//   pix (slave)                : framebuffer pixel stream, see lcd_video_timing_if
//   underflow_clr_i            : clears the sticky underflow flag
//   hsync_o, vsync_o, blank_o  : active-high timing
//   r_o, g_o, b_o              : pixel colour, 0 while blanked or unsynced
//   frame_start_o              : one-cycle pulse with the (0,0) outputs
//   underflow_o                : sticky underflow / misalignment flag
//   synced_o                   : sequencer is locked to the stream
module lcd_video_timing
    import lcd_pkg::*;
#(
    parameter int CLKS_PER_PIXEL = DEF_CLKS_PER_PIXEL,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic                 pixel_clk_i,
    input  logic                 pixel_rst_n_i,
    lcd_video_timing_if.slave    pix,
    input  logic                 underflow_clr_i,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 blank_o,
    output logic [7:0]           r_o,
    output logic [7:0]           g_o,
    output logic [7:0]           b_o,
    output logic                 frame_start_o,
    output logic                 underflow_o,
    output logic                 synced_o
);
    lcd_state_e state_r;
    rgb888_t    rgb_r;
    logic       hsync_s;
    logic       vsync_s;
    logic       active_s;
    logic       fetch_slot_s;
    logic       frame_origin_s;
    logic       rdy_s;
    logic       misalign_s;

    lcd_timing_cnt #(
        .CLKS_PER_PIXEL (CLKS_PER_PIXEL),
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_cnt (
        .clk          (pixel_clk_i),
        .rst_n        (pixel_rst_n_i),
        .hsync        (hsync_s),
        .vsync        (vsync_s),
        .active       (active_s),
        .fetch_slot   (fetch_slot_s),
        .frame_origin (frame_origin_s)
    );

    // Ready: an SOF word is only ever taken at the frame origin, so a
    // misplaced SOF stays at the stream head. RESYNC drains every other
    // word each clock; SYNCED takes words only in fetch slots.
    always_comb begin
        rdy_s      = 1'b0;
        misalign_s = pix.pix_sof_i != frame_origin_s;
        if (pix.pix_valid_i && (!pix.pix_sof_i || frame_origin_s)) begin
            if (state_r == RESYNC) begin
                rdy_s = 1'b1;
            end else begin
                rdy_s = fetch_slot_s;
            end
        end else begin
            rdy_s = 1'b0;
        end
    end

    assign pix.pix_rdy_o = rdy_s;
    assign r_o      = rgb_r.r;
    assign g_o      = rgb_r.g;
    assign b_o      = rgb_r.b;
    assign synced_o = (state_r == SYNCED);

    // Sequencer FSM and registered video outputs.
    always_ff @(posedge pixel_clk_i or negedge pixel_rst_n_i) begin
        if (!pixel_rst_n_i) begin
            state_r       <= RESYNC;
            rgb_r         <= '0;
            hsync_o       <= 1'b0;
            vsync_o       <= 1'b0;
            blank_o       <= 1'b1;
            frame_start_o <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            hsync_o       <= hsync_s;
            vsync_o       <= vsync_s;
            blank_o       <= !active_s;
            frame_start_o <= frame_origin_s;
            case (state_r)
                RESYNC: begin
                    underflow_o <= underflow_o && !underflow_clr_i;
                    if (frame_origin_s && pix.pix_valid_i && pix.pix_sof_i) begin
                        rgb_r   <= rgb888_unpack(pix.pix_data_i);
                        state_r <= SYNCED;
                    end else begin
                        rgb_r <= '0;
                    end
                end
                SYNCED: begin
                    if (!fetch_slot_s) begin
                        underflow_o <= underflow_o && !underflow_clr_i;
                        // Hold the pixel for its remaining phases.
                        if (active_s) begin
                            rgb_r <= rgb_r;
                        end else begin
                            rgb_r <= '0;
                        end
                    end else if (!pix.pix_valid_i) begin
                        // Starved slot: show black, keep lock.
                        underflow_o <= 1'b1;
                        rgb_r       <= '0;
                    end else if (misalign_s) begin
                        underflow_o <= 1'b1;
                        rgb_r       <= '0;
                        state_r     <= RESYNC;
                    end else begin
                        underflow_o <= underflow_o && !underflow_clr_i;
                        rgb_r       <= rgb888_unpack(pix.pix_data_i);
                    end
                end
                default: begin
                    underflow_o <= 1'b1;
                    rgb_r       <= '0;
                    state_r     <= RESYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_video_timing.sv
// tb_lcd_video_timing: directed bench for lcd_video_timing with a tiny
// 4x3 panel (3 clocks/pixel, 8 pixels/line, 6 lines/frame, 144 clocks/frame).
// k counts rising edges since reset release; after k edges the outputs
// describe counter position p = k-1.
module tb_lcd_video_timing;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        hsync, vsync, blank, frame_start, underflow, synced;
    logic [7:0]  r, g, b;

    lcd_video_timing_if pix_if ();

    lcd_video_timing #(
        .CLKS_PER_PIXEL (3),
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut (
        .pixel_clk_i     (clk),
        .pixel_rst_n_i   (rst_n),
        .pix             (pix_if.slave),
        .underflow_clr_i (underflow_clr),
        .hsync_o         (hsync),
        .vsync_o         (vsync),
        .blank_o         (blank),
        .r_o             (r),
        .g_o             (g),
        .b_o             (b),
        .frame_start_o   (frame_start),
        .underflow_o     (underflow),
        .synced_o        (synced)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          k = 0;
    int          scn = 0;
    logic [24:0] q[$];
    logic        took;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (scenario %0d, k=%0d): got 0x%0h, expected 0x%0h",
                     tag, scn, k, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_col(input int p);
        int h, v, f;
        h = (p / 3) % 8;
        v = (p / 24) % 6;
        f = p / 144;
        if (h >= 4 || v >= 3) return 24'h0;
        case (scn)
            2, 6:    return 24'(v * 4 + h + 1);
            3:       return (p >= 30 && p <= 32) ? 24'h0 : 24'(v * 4 + h + 1);
            4:       return (f == 0) ? ((p < 3) ? 24'h1 : 24'h0) : 24'(32'h100 + v * 4 + h + 1);
            5:       return (f == 0) ? 24'h0 : 24'(v * 4 + h + 1);
            default: return 24'h0;
        endcase
    endfunction

    function automatic logic exp_sync(input int kk);
        case (scn)
            2, 3, 6: return kk >= 1;
            4:       return (kk >= 1 && kk <= 3) || kk >= 145;
            5:       return kk >= 145;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_ufl(input int kk);
        case (scn)
            3:       return kk >= 31 && kk <= 200;
            4:       return kk >= 4;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_reset_state();
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_fstart", 32'(frame_start), 32'd0);
        chk("rst_ufl", 32'(underflow), 32'd0);
        chk("rst_synced", 32'(synced), 32'd0);
    endtask

    task automatic check_outputs();
        int p, h, v;
        p = k - 1;
        h = (p / 3) % 8;
        v = (p / 24) % 6;
        chk("hsync", 32'(hsync), 32'(h == 5 || h == 6));
        chk("vsync", 32'(vsync), 32'(v == 4));
        chk("blank", 32'(blank), 32'(!(h < 4 && v < 3)));
        chk("frame_start", 32'(frame_start), 32'(p % 144 == 0));
        chk("rgb", 32'({r, g, b}), 32'(exp_col(p)));
        chk("underflow", 32'(underflow), 32'(exp_ufl(k)));
        chk("synced", 32'(synced), 32'(exp_sync(k)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pix_if.pix_valid_i = 1'b0;
        pix_if.pix_sof_i   = 1'b0;
        pix_if.pix_data_i  = 24'h0;
        underflow_clr      = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        check_reset_state();
    endtask

    // Frame of 12 words, base+1 .. base+12, SOF on the first.
    task automatic push_frame(input logic [23:0] base, input int skip_idx);
        for (int i = 0; i < 12; i++) begin
            if (i != skip_idx) q.push_back({(i == 0), 24'(base + 24'(i + 1))});
        end
    endtask

    task automatic run(input int ticks);
        for (int i = 0; i < ticks; i++) begin
            pix_if.pix_valid_i = (q.size() > 0) && !(scn == 3 && k == 30);
            if (q.size() > 0) begin
                {pix_if.pix_sof_i, pix_if.pix_data_i} = q[0];
            end else begin
                {pix_if.pix_sof_i, pix_if.pix_data_i} = 25'h0;
            end
            underflow_clr = (scn == 3 && k == 200);
            #4;
            took = pix_if.pix_rdy_o;
            if (scn == 4 && k == 3)   chk("early_sof_held", 32'(took), 32'd0);
            if (scn == 4 && k == 144) chk("early_sof_taken", 32'(took), 32'd1);
            if (scn == 5 && k < 5)    chk("drain_rdy", 32'(took), 32'd1);
            if (scn == 5 && k == 5)   chk("late_sof_held", 32'(took), 32'd0);
            @(negedge clk);
            k++;
            if (took && q.size() > 0) void'(q.pop_front());
            check_outputs();
        end
    endtask

    initial begin
        pix_if.pix_valid_i = 1'b0;
        pix_if.pix_sof_i   = 1'b0;
        pix_if.pix_data_i  = 24'h0;

        // 1: idle stream, two frames of timing only.
        scn = 1; do_reset(); run(288);

        // 2: continuous stream over three frames.
        scn = 2; do_reset();
        for (int f = 0; f < 3; f++) push_frame(24'h0, -1);
        run(432);
        chk("stream_drained", 32'(q.size()), 32'd0);

        // 3: one-slot gap at pixel (2,1); that word never arrives.
        scn = 3; do_reset();
        push_frame(24'h0, 6);
        push_frame(24'h0, -1);
        run(288);

        // 4: early SOF at pixel (1,0).
        scn = 4; do_reset();
        q.push_back({1'b1, rgb888_pack(rgb888_unpack(24'h000001))});
        push_frame(24'h100, -1);
        run(288);

        // 5: five stale words ahead of the SOF frame.
        scn = 5; do_reset();
        for (int i = 1; i <= 5; i++) q.push_back({1'b0, 24'(24'hBAD000 + 24'(i))});
        push_frame(24'h0, -1);
        run(288);
        chk("late_sof_drained", 32'(q.size()), 32'd0);

        // 6: reset in the middle of active pixel (1,1).
        scn = 6; do_reset();
        push_frame(24'h0, -1);
        run(28);
        chk("pre_rst_rgb", 32'({r, g, b}), 32'h6);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        do_reset();
        push_frame(24'h0, -1);
        run(144);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
